// File: rtl/rx_pkt_pkg.sv
// Shared definitions for the RX packetizer.
//   state_e       : packetizer FSM states
//   HDR_TAG       : tag byte in the top of every header word
//   TRL_TAG       : tag byte in the top of every trailer word
//   make_header   : header word for a peripheral id
//   make_trailer  : trailer word for a peripheral id and data-beat count
package rx_pkt_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    HEADER  = 3'd1,
    DATA    = 3'd2,
    TRAILER = 3'd3,
    RELEASE = 3'd4
  } state_e;

  localparam logic [7:0] HDR_TAG = 8'hC0;
  localparam logic [7:0] TRL_TAG = 8'hE0;

  function automatic logic [31:0] make_header(input logic [2:0] id);
    return {HDR_TAG, 21'b0, id};
  endfunction

  function automatic logic [31:0] make_trailer(input logic [2:0] id,
                                               input logic [15:0] count);
    return {TRL_TAG, 5'b0, id, count};
  endfunction

endpackage

// File: rtl/rx_packetizer.sv
// RX packetizer: drains the FWFT RX FIFO selected by the arbiter grant in
// bursts of up to MAX_BURST words and frames each burst as
// header / data... / trailer on a valid/ready stream.
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   grant             arbiter choice, sampled only in IDLE
//   read_periph_data  one-cycle pulse asking the arbiter to re-arbitrate
//   rx_fifo_empty     per-FIFO empty flags
//   rx_fifo_dout      packed FWFT heads, FIFO i at [i*DATA_WIDTH +: DATA_WIDTH]
//   rx_fifo_rd_en     per-FIFO pop strobes (one-hot or zero)
//   tx_data/tx_valid/tx_ready/tx_last  outgoing stream, tx_last on trailer
module rx_packetizer
  import rx_pkt_pkg::*;
#(
  parameter int NUM_PERIPH = 8,
  parameter int DATA_WIDTH = 32,
  parameter int MAX_BURST  = 16
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic [2:0]                       grant,
  output logic                             read_periph_data,
  input  logic [NUM_PERIPH-1:0]            rx_fifo_empty,
  input  logic [NUM_PERIPH*DATA_WIDTH-1:0] rx_fifo_dout,
  output logic [NUM_PERIPH-1:0]            rx_fifo_rd_en,
  output logic [DATA_WIDTH-1:0]            tx_data,
  output logic                             tx_valid,
  input  logic                             tx_ready,
  output logic                             tx_last
);

  localparam logic [16:0] MAX_B = 17'(MAX_BURST);

  state_e      state_q, state_d;
  logic [2:0]  cur_id_q, cur_id_d;
  logic [15:0] count_q, count_d;

  logic                  head_empty;
  logic [DATA_WIDTH-1:0] head_data;
  logic [16:0]           count_inc;

  // Only cur_id selects the FIFO once a packet is underway; grant is ignored.
  assign head_empty = rx_fifo_empty[cur_id_q];
  assign head_data  = rx_fifo_dout[int'(cur_id_q)*DATA_WIDTH +: DATA_WIDTH];
  // One bit wider than the counter so the MAX_BURST compare cannot alias.
  assign count_inc  = {1'b0, count_q} + 17'd1;

  always_comb begin
    state_d          = state_q;
    cur_id_d         = cur_id_q;
    count_d          = count_q;
    tx_valid         = 1'b0;
    tx_data          = '0;
    tx_last          = 1'b0;
    read_periph_data = 1'b0;
    rx_fifo_rd_en    = '0;
    unique case (state_q)
      IDLE: begin
        cur_id_d = grant;
        state_d  = rx_fifo_empty[grant] ? RELEASE : HEADER;
      end
      HEADER: begin
        tx_valid = 1'b1;
        tx_data  = make_header(cur_id_q);
        if (tx_ready) begin
          count_d = '0;
          state_d = DATA;
        end
      end
      DATA: begin
        // Valid follows the FIFO head; it can only fall after our own pop,
        // so a stalled beat is never withdrawn.
        tx_valid = !head_empty;
        tx_data  = head_data;
        if (tx_valid && tx_ready) begin
          rx_fifo_rd_en[cur_id_q] = 1'b1;
          count_d                 = count_inc[15:0];
          if (count_inc == MAX_B) state_d = TRAILER;
        end else if (head_empty && count_q != 16'd0) begin
          state_d = TRAILER;
        end
      end
      TRAILER: begin
        tx_valid = 1'b1;
        tx_last  = 1'b1;
        tx_data  = make_trailer(cur_id_q, count_q);
        if (tx_ready) state_d = RELEASE;
      end
      RELEASE: begin
        // The arbiter moves grant on this edge, so IDLE sees the new choice.
        read_periph_data = 1'b1;
        state_d          = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      cur_id_q <= '0;
      count_q  <= '0;
    end else begin
      state_q  <= state_d;
      cur_id_q <= cur_id_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: tb/tb_rx_packetizer.sv
// Directed bench for rx_packetizer with a behavioural FWFT FIFO model per
// peripheral, a stream capture log and pop/stall monitors.
module tb_rx_packetizer;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [2:0]   grant;
  logic         read_periph_data;
  logic [7:0]   rx_fifo_empty;
  logic [255:0] rx_fifo_dout;
  logic [7:0]   rx_fifo_rd_en;
  logic [31:0]  tx_data;
  logic         tx_valid;
  logic         tx_ready;
  logic         tx_last;

  rx_packetizer #(.NUM_PERIPH(8), .DATA_WIDTH(32), .MAX_BURST(16)) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .grant            (grant),
    .read_periph_data (read_periph_data),
    .rx_fifo_empty    (rx_fifo_empty),
    .rx_fifo_dout     (rx_fifo_dout),
    .rx_fifo_rd_en    (rx_fifo_rd_en),
    .tx_data          (tx_data),
    .tx_valid         (tx_valid),
    .tx_ready         (tx_ready),
    .tx_last          (tx_last)
  );

  always #5 clk = ~clk;

  // FIFO model: wr_ptr advanced by stimulus, rd_ptr by accepted pops.
  logic [31:0] mem [8][64];
  int          wr_ptr [8] = '{default: 0};
  int          rd_ptr [8] = '{default: 0};
  logic [7:0]  pop_pend = '0;

  always_comb begin
    rx_fifo_empty = '0;
    rx_fifo_dout  = '0;
    for (int i = 0; i < 8; i++) begin
      rx_fifo_empty[i]         = (rd_ptr[i] == wr_ptr[i]);
      rx_fifo_dout[i*32 +: 32] = mem[i][rd_ptr[i] % 64];
    end
  end

  always @(posedge clk) begin
    for (int i = 0; i < 8; i++)
      if (pop_pend[i]) rd_ptr[i] <= rd_ptr[i] + 1;
  end

  // Monitor, sampled mid-cycle when all signals are settled.
  logic [31:0] cap [256];
  bit          cap_last [256];
  int          cap_n = 0;
  int          pop_cnt [8] = '{default: 0};
  int          pop_err = 0;
  int          stab_err = 0;
  bit          prev_stall = 1'b0;
  logic [31:0] prev_data = '0;

  always @(negedge clk) begin
    if (!rst_n) begin
      prev_stall <= 1'b0;
      pop_pend   <= '0;
    end else begin
      if (prev_stall && !(tx_valid && tx_data == prev_data)) stab_err <= stab_err + 1;
      prev_stall <= tx_valid && !tx_ready;
      prev_data  <= tx_data;
      if (tx_valid && tx_ready) begin
        cap[cap_n & 255]      <= tx_data;
        cap_last[cap_n & 255] <= tx_last;
        cap_n                 <= cap_n + 1;
      end
      pop_pend <= rx_fifo_rd_en;
      if ($countones(rx_fifo_rd_en) > 1 || (rx_fifo_rd_en & rx_fifo_empty) != 8'b0 ||
          (rx_fifo_rd_en != 8'b0 && !(tx_valid && tx_ready)))
        pop_err <= pop_err + 1;
      for (int i = 0; i < 8; i++)
        if (rx_fifo_rd_en[i]) pop_cnt[i] <= pop_cnt[i] + 1;
    end
  end

  int n_cmp = 0;
  int n_mis = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_mis++;
      $display("FAIL %s: got %08h expected %08h", tag, got, exp);
    end
  endtask

  task automatic load(input int id, input int n, input logic [31:0] first);
    for (int k = 0; k < n; k++) begin
      mem[id][wr_ptr[id] % 64] = first + 32'(k);
      wr_ptr[id] = wr_ptr[id] + 1;
    end
  endtask

  // Returns in the cycle after the target beat was accepted.
  task automatic wait_beats(input string tag, input int target, input bit rnd);
    int n = 0;
    while (cap_n < target && n < 600) begin
      @(posedge clk); #1;
      if (rnd) tx_ready = ($urandom_range(0, 9) >= 3);
      n++;
    end
    check_eq({tag, "_beats"}, cap_n, target);
  endtask

  task automatic check_pkt(input string tag, input int base, input logic [31:0] hdr,
                           input logic [31:0] trl, input int n, input logic [31:0] first);
    int lasts = 0;
    check_eq({tag, "_hdr"}, cap[base & 255], hdr);
    lasts += int'(cap_last[base & 255]);
    for (int k = 0; k < n; k++) begin
      check_eq($sformatf("%s_d%0d", tag, k), cap[(base + 1 + k) & 255], first + 32'(k));
      lasts += int'(cap_last[(base + 1 + k) & 255]);
    end
    check_eq({tag, "_trl"}, cap[(base + n + 1) & 255], trl);
    check_eq({tag, "_last"}, 32'(cap_last[(base + n + 1) & 255]), 32'd1);
    check_eq({tag, "_nolast"}, lasts, 0);
  endtask

  task automatic check_quiet(input string tag);
    check_eq({tag, "_vld"}, {31'b0, tx_valid}, 0);
    check_eq({tag, "_data"}, tx_data, 0);
    check_eq({tag, "_last"}, {31'b0, tx_last}, 0);
    check_eq({tag, "_rpd"}, {31'b0, read_periph_data}, 0);
    check_eq({tag, "_rden"}, {24'b0, rx_fifo_rd_en}, 0);
  endtask

  int base;
  int p0 [8];
  int others;

  initial begin
    rst_n    = 1'b0;
    grant    = 3'd6;
    tx_ready = 1'b1;

    // Reset and empty-grant loop.
    repeat (3) @(posedge clk);
    #1 check_quiet("rst");
    rst_n = 1'b1;
    @(negedge clk);
    check_quiet("post_rst");
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      check_eq($sformatf("empty_rpd%0d", k), {31'b0, read_periph_data}, (k % 2 == 0) ? 1 : 0);
      check_eq($sformatf("empty_vld%0d", k), {31'b0, tx_valid}, 0);
      check_eq($sformatf("empty_rden%0d", k), {24'b0, rx_fifo_rd_en}, 0);
    end

    // Five-word burst from FIFO3.
    @(posedge clk); #1;
    base = cap_n;
    p0   = pop_cnt;
    grant = 3'd3;
    load(3, 5, 32'h11);
    wait_beats("p3", base + 7, 1'b0);
    check_eq("p3_rpd", {31'b0, read_periph_data}, 1);
    check_pkt("p3", base, 32'hC0000003, 32'hE0030005, 5, 32'h11);
    check_eq("p3_pops", pop_cnt[3] - p0[3], 5);
    others = 0;
    for (int i = 0; i < 8; i++) if (i != 3) others += pop_cnt[i] - p0[i];
    check_eq("p3_other_pops", others, 0);

    // Twenty words from FIFO0 split at MAX_BURST.
    @(posedge clk); #1;
    base = cap_n;
    grant = 3'd0;
    load(0, 20, 32'h100);
    wait_beats("p0", base + 24, 1'b0);
    check_pkt("p0a", base, 32'hC0000000, 32'hE0000010, 16, 32'h100);
    check_pkt("p0b", base + 18, 32'hC0000000, 32'hE0000004, 4, 32'h110);

    // Seven words from FIFO5 under random backpressure.
    @(posedge clk); #1;
    base = cap_n;
    grant = 3'd5;
    load(5, 7, 32'h50);
    wait_beats("p5", base + 9, 1'b1);
    tx_ready = 1'b1;
    check_pkt("p5", base, 32'hC0000005, 32'hE0050007, 7, 32'h50);
    check_eq("p5_stable", stab_err, 0);

    // Grant moves from 2 to 4 mid-burst; FIFO4 must not be touched.
    @(posedge clk); #1;
    base = cap_n;
    p0   = pop_cnt;
    grant = 3'd2;
    load(2, 6, 32'h20);
    wait_beats("p2_start", base + 2, 1'b0);
    grant = 3'd4;
    load(4, 3, 32'h40);
    wait_beats("p2", base + 8, 1'b0);
    check_pkt("p2", base, 32'hC0000002, 32'hE0020006, 6, 32'h20);
    check_eq("p2_pops2", pop_cnt[2] - p0[2], 6);
    check_eq("p2_pops4", pop_cnt[4] - p0[4], 0);
    wait_beats("p4", base + 13, 1'b0);
    check_pkt("p4", base + 8, 32'hC0000004, 32'hE0040003, 3, 32'h40);

    // Reset in the middle of a DATA burst on FIFO1.
    @(posedge clk); #1;
    base = cap_n;
    grant = 3'd1;
    load(1, 10, 32'h30);
    wait_beats("p1_start", base + 3, 1'b0);
    rst_n = 1'b0;
    #1 check_quiet("mid_rst");
    grant = 3'd6;
    @(posedge clk); #1;
    wr_ptr[1] = rd_ptr[1];
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    check_quiet("mid_post_rst");
    @(posedge clk); #1;
    base = cap_n;
    grant = 3'd1;
    load(1, 2, 32'hA0);
    wait_beats("p1", base + 4, 1'b0);
    check_pkt("p1", base, 32'hC0000001, 32'hE0010002, 2, 32'hA0);

    repeat (2) @(posedge clk);
    check_eq("pop_rules", pop_err, 0);
    check_eq("stall_stable", stab_err, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule

// File: doc/rx_packetizer.md
Name: rx_packetizer

Overview:
- Sits directly downstream of the RX arbiter.
- Consumes the arbiter's `grant`, drains the granted peripheral RX FIFO (first-word-fall-through) in a bounded burst, and frames it as header / data / trailer words on a valid/ready stream toward the host link.
- Pulses `read_periph_data` after each burst, or on an empty grant, so the arbiter advances to its next choice.

Parameters:
- NUM_PERIPH, 8, number of peripheral RX FIFOs; `grant` width is clog2(NUM_PERIPH)=3.
- DATA_WIDTH, 32, FIFO and stream word width; must be 32.
- MAX_BURST, 16, max data words per packet; range 1..65535.

Ports:
- clk  in  1  system clock; all state on rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- grant  in  3  current arbiter grant; stable while read_periph_data is low.
- read_periph_data  out  1  one-cycle pulse requesting the arbiter to re-arbitrate.
- rx_fifo_empty  in  NUM_PERIPH  per-FIFO empty flags.
- rx_fifo_dout  in  NUM_PERIPH*DATA_WIDTH  packed FWFT heads; FIFO i occupies [i*32+:32].
- rx_fifo_rd_en  out  NUM_PERIPH  per-FIFO pop strobes; one-hot or zero.
- tx_data  out  32  stream word.
- tx_valid  out  1  stream valid.
- tx_ready  in  1  stream ready; a beat transfers when tx_valid & tx_ready.
- tx_last  out  1  high on the trailer beat only.

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE, cur_id=0, count=0.
  - All outputs 0 combinationally during reset and in the first cycle after.
- States:
  - IDLE: on the next edge, latch cur_id<=grant.
    - If !rx_fifo_empty[grant], go to HEADER.
    - Otherwise go to RELEASE.
  - HEADER: tx_valid=1, tx_data={8'hC0,21'b0,cur_id}. On accept: count<=0, go to DATA.
  - DATA:
    - tx_valid=!rx_fifo_empty[cur_id], tx_data=rx_fifo_dout[cur_id].
    - rx_fifo_rd_en[cur_id]=tx_valid&tx_ready; on accept, count<=count+1.
    - Go to TRAILER when (accept and count+1==MAX_BURST) or (rx_fifo_empty[cur_id] and count>=1).
    - The first data beat is guaranteed: only this block pops, so the FIFO cannot empty between IDLE and DATA.
  - TRAILER: tx_valid=1, tx_last=1, tx_data={8'hE0,5'b0,cur_id,count[15:0]}. On accept, go to RELEASE.
  - RELEASE: read_periph_data=1 for exactly one cycle, then go to IDLE. The arbiter updates grant on that edge, so IDLE sees the new grant.
- Stream rules:
  - Once tx_valid is high it stays high, with tx_data stable, until accepted.
  - tx_ready low stalls any state indefinitely.
  - There is no timeout.
- Pops:
  - rx_fifo_rd_en is never asserted outside DATA.
  - rx_fifo_rd_en is never asserted to a FIFO other than cur_id.
  - rx_fifo_rd_en is never asserted when that FIFO is empty.
- Grant isolation: changes on `grant` outside IDLE are ignored; cur_id governs.
- Count width: 16 bits, compare against MAX_BURST exactly; no wrap possible given the parameter range.
- Burst end: the trailer count equals the number of data beats, 1..MAX_BURST.
- Empty grant: IDLE→RELEASE→IDLE loop, one pulse every 2 cycles, with no stream traffic.
- Mid-operation reset:
  - Abandon the packet immediately.
  - No trailer is sent.
  - Popped words are lost.
  - The next packet starts clean after reset.
- Simultaneous events:
  - In DATA, if the last available word is accepted in the same cycle the FIFO becomes empty, the next cycle observes empty and transitions to TRAILER.
  - If that accept also reaches MAX_BURST, go to TRAILER directly.

Decomposition:
- Package rx_pkt_pkg holds:
  - state enum (IDLE, HEADER, DATA, TRAILER, RELEASE);
  - HDR_TAG=8'hC0 and TRL_TAG=8'hE0;
  - functions make_header(id) and make_trailer(id,count).
- No sub-module; the FIFO head mux is an indexed part-select inside the block.

Test Plan:
- Reset with rst_n=0 mid-DATA: all outputs drop to 0 asynchronously. After release, state is IDLE and no pop is asserted.
- grant=3, FIFO3 holds 5 words (0x11..0x15), tx_ready=1: stream C0000003, 11,12,13,14,15, E0030005 with tx_last; one read_periph_data pulse; 5 pops on rd_en[3] only.
- grant=0, FIFO0 holds 20 words, MAX_BURST=16: first packet has 16 data beats and trailer E0000010. After RELEASE with grant still 0, the second packet has 4 beats and trailer E0000004.
- Random tx_ready backpressure with 30% low on a 7-word burst from FIFO5: tx_data is stable while stalled, there are no duplicate or skipped words, and the trailer count is 7.
- grant=6 with FIFO6 empty: read_periph_data toggles 1,0,1,0; tx_valid stays 0; no rd_en.
- grant changes from 2 to 4 during a DATA burst on FIFO2: pops stay on rd_en[2], and the header and trailer id remain 2.
